// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register carrying an opaque WIDTH-bit payload, with a 2-entry skid buffer,
// synchronous flush, a sticky halt detector and a saturating stall counter.
module pipe_stage_skid #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               HALT_BIT  = 0,
    parameter int               CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic             halt_seen,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               halt_q, halt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push, pop;

    // in_ready is a function of registered state only, so no comb path from out_ready.
    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = (state_q != S_FULL) && !halt_q;
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign halt_seen = halt_q;
    assign stall_cnt = cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        halt_d  = halt_q;
        cnt_d   = cnt_q;

        // A pop coinciding with flush was already sampled downstream, so it still counts.
        if (pop && main_q[HALT_BIT])
            halt_d = 1'b1;

        if (out_valid && !out_ready && !flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;

        if (flush) begin
            state_d = S_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        main_d  = in_data;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        skid_d  = in_data;
                        state_d = S_FULL;
                    end else if (pop) begin
                        main_d  = NOP_VALUE;
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                        state_d = S_ONE;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= S_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized bench for pipe_stage_skid, checked every cycle against a queue-based model.
module tb_pipe_stage_skid;

    localparam int               W    = 9;
    localparam logic [W-1:0]     NOP  = 9'h0EE;
    localparam int               HB   = 8;
    localparam int               CW   = 4;
    localparam int               SMAX = (1 << CW) - 1;

    logic          CLK;
    logic          nRST;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic          halt_seen;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: held entries in arrival order, sticky halt flag, stall count.
    logic [W-1:0] mq[$];
    bit           mhalt;
    int           mstall;

    pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP), .HALT_BIT(HB), .CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .halt_seen(halt_seen), .stall_cnt(stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs against the model, advance model and DUT.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic rst_n);
        bit e_valid, e_ready, psh, pp;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        nRST      = rst_n;
        #1;
        e_valid = (mq.size() != 0);
        e_ready = (mq.size() < 2) && !mhalt;
        chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
        chk("in_ready",  {31'b0, in_ready},  {31'b0, e_ready});
        chk("out_data",  {23'b0, out_data},  {23'b0, (e_valid ? mq[0] : NOP)});
        chk("occupancy", {30'b0, occupancy}, mq.size());
        chk("halt_seen", {31'b0, halt_seen}, {31'b0, mhalt});
        chk("stall_cnt", {28'b0, stall_cnt}, mstall);
        psh = v && e_ready;
        pp  = e_valid && ordy;
        if (!rst_n) begin
            mq.delete();
            mhalt  = 0;
            mstall = 0;
        end else begin
            if (pp && mq[0][HB]) mhalt = 1;
            if (e_valid && !ordy && !fl && mstall < SMAX) mstall++;
            if (fl) mq.delete();
            else begin
                if (pp)  void'(mq.pop_front());
                if (psh) mq.push_back(d);
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [W-1:0] rd;
        in_valid = 0; in_data = '0; out_ready = 0; flush = 0; nRST = 0;
        @(posedge CLK);
        @(negedge CLK);
        mq.delete(); mhalt = 0; mstall = 0;

        // Streaming at full throughput
        cycle(1, 9'h011, 1, 0, 1);
        cycle(1, 9'h022, 1, 0, 1);
        cycle(1, 9'h033, 1, 0, 1);
        cycle(0, 9'h000, 1, 0, 1);
        cycle(0, 9'h000, 1, 0, 1);

        // Backpressure into the skid slot, then drain
        cycle(1, 9'h0A1, 0, 0, 1);
        cycle(1, 9'h0A2, 0, 0, 1);
        cycle(1, 9'h0A3, 0, 0, 1);
        cycle(0, 9'h000, 0, 0, 1);
        cycle(0, 9'h000, 1, 0, 1);
        cycle(0, 9'h000, 1, 0, 1);
        cycle(0, 9'h000, 1, 0, 1);

        // Flush while full with a concurrent offer that must be dropped
        cycle(1, 9'h0B1, 0, 0, 1);
        cycle(1, 9'h0B2, 0, 0, 1);
        cycle(1, 9'h0B3, 0, 1, 1);
        cycle(0, 9'h000, 1, 0, 1);
        chk("flush_nop", {23'b0, out_data}, {23'b0, NOP});

        // Halt marker leaves the stage; later offer blocked; flush keeps halt
        cycle(1, 9'h040, 1, 0, 1);
        cycle(1, 9'h141, 1, 0, 1);
        cycle(1, 9'h050, 1, 0, 1);
        cycle(1, 9'h051, 1, 0, 1);
        cycle(1, 9'h052, 1, 0, 1);
        cycle(1, 9'h053, 0, 1, 1);
        cycle(1, 9'h054, 1, 0, 1);
        chk("halt_sticky", {31'b0, halt_seen}, 32'd1);
        cycle(0, 9'h000, 1, 0, 0);

        // Stall counter saturation
        cycle(1, 9'h060, 0, 0, 1);
        for (int i = 0; i < 20; i++) cycle(0, 9'h000, 0, 0, 1);
        chk("stall_sat", {28'b0, stall_cnt}, SMAX);
        cycle(0, 9'h000, 0, 1, 1);

        // Reset while full, then resume streaming
        cycle(1, 9'h070, 0, 0, 1);
        cycle(1, 9'h071, 0, 0, 1);
        cycle(1, 9'h072, 1, 0, 0);
        chk("rst_occ", {30'b0, occupancy}, 32'd0);
        cycle(1, 9'h077, 1, 0, 1);
        cycle(1, 9'h077, 1, 0, 1);
        cycle(1, 9'h077, 1, 0, 1);
        cycle(0, 9'h000, 1, 0, 1);

        // Randomized traffic with occasional flush, halt payloads and reset
        for (int i = 0; i < 600; i++) begin
            rd = W'($urandom_range(0, 255));
            if ($urandom_range(0, 40) == 0) rd[HB] = 1'b1;
            cycle(1'($urandom_range(0, 3) != 0), rd,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 50) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised elastic pipeline register that generalises the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one payload-width-agnostic stage.
- Payload is an opaque packed WIDTH-bit vector; the owning stage packs and unpacks its control and data fields.
- Adds a valid/ready handshake with a 2-entry skid buffer, so ready is registered-only with full throughput.
- Adds synchronous flush for bubble insertion, a sticky halt detector and a saturating stall counter.
- Sits between any two pipeline stages of the datapath.

Parameters:
WIDTH, 32, payload width in bits (>=2)
NOP_VALUE, '0, payload value held in empty/flushed slots (bubble)
HALT_BIT, 0, payload bit index marking a halt instruction (0..WIDTH-1)
CNT_W, 16, stall counter width

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  synchronous active-low reset, sampled on the rising edge of CLK
in_valid  input  1  upstream offers in_data
in_ready  output  1  stage can accept this cycle
in_data  input  WIDTH  upstream payload
flush  input  1  synchronous squash of all held entries
out_valid  output  1  out_data holds a real entry
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  head payload (main register)
occupancy  output  2  number of held entries, 0..2
halt_seen  output  1  sticky: a halt payload has left the stage
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage and state:
  - main and skid registers, each WIDTH bits.
  - State EMPTY/ONE/FULL, encoded as occupancy 0/1/2.
- Handshake events:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
- Combinational outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL) & !halt_seen.
  - in_ready depends on registered state only; there is no combinational path from out_ready or in_valid.
  - out_data = main register directly; zero-cycle latency from register.
- Latency: in_data accepted at edge N appears on out_data after edge N, i.e. usable in cycle N+1. With out_ready held at 1, sustains one transfer per cycle.
- Transitions (no flush):
  - EMPTY, push: main<=in_data, ONE.
  - ONE, push&pop: main<=in_data, stay ONE.
  - ONE, push&!pop: skid<=in_data, FULL.
  - ONE, pop&!push: main<=NOP_VALUE, EMPTY.
  - ONE, neither: hold.
  - FULL: push impossible (in_ready=0). On pop: main<=skid, skid<=NOP_VALUE, ONE. Otherwise hold.
- Ordering: strict FIFO; skid is never presented before main.
- Flush (priority over push/pop, below reset):
  - Next state EMPTY; main and skid <= NOP_VALUE.
  - Any push in the same cycle is dropped.
  - A pop in the same cycle still counts for halt_seen; the downstream has already sampled the data.
- halt_seen:
  - Set at the edge where pop=1 and out_data[HALT_BIT]=1.
  - Cleared only by reset; flush does not clear it.
  - Once set, in_ready=0 permanently. Remaining held entries still drain.
- stall_cnt:
  - Increments at each edge where out_valid=1 and out_ready=0, unless flush=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Reset only by nRST.
- Reset (nRST=0 at an edge, overrides all):
  - State EMPTY; main and skid = NOP_VALUE; halt_seen=0; stall_cnt=0.
  - Resulting outputs: out_valid=0, out_data=NOP_VALUE, occupancy=0, in_ready=1.
  - Reset asserted mid-transfer discards all held entries; no partial state survives.
- Held data is stable: main does not change while out_valid=1 and out_ready=0, except on flush.
- No X propagation: skid always holds NOP_VALUE when not occupied.

Test Plan:
1. Reset, then stream 0x11,0x22,0x33 with in_valid=1 and out_ready=1 every cycle -> out_data 0x11,0x22,0x33 on consecutive cycles one cycle after acceptance; occupancy stays 1; stall_cnt=0.
2. Backpressure: push 0xA1 and 0xA2 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA1 stable, stall_cnt increments each cycle. Then raise out_ready for 2 cycles -> 0xA1 then 0xA2 emerge, occupancy 2->1->0.
3. Flush while FULL (0xB1,0xB2) with in_valid=1 carrying 0xB3 -> next cycle out_valid=0, out_data=NOP_VALUE, occupancy=0. 0xB3 never appears at the output.
4. Halt: push 0x40, 0x41 (HALT_BIT=0 set), 0x50 with out_ready=1 -> halt_seen rises the edge after 0x41 is popped; in_ready=0 from then on; 0x50 either drains if already held or is never accepted. Flush does not clear halt_seen.
5. Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays there.
6. Reset mid-operation: with occupancy=2, drive nRST=0 for one edge -> all outputs return to reset values. Subsequent stream of 0x77 behaves as in scenario 1.
